// File: rtl/booth_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_mul
//  Purpose  : Iterative radix-2 Booth signed multiplier. One Booth digit is
//             retired per clock over WIDTH cycles through a single
//             add/subtract datapath, accumulating a 2*WIDTH-bit product.
//             Operands arrive over a valid/ready handshake and the product
//             leaves over a second valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_1,
    input  logic [WIDTH-1:0]     op_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    // Product width and step counter width. The counter carries one extra
    // bit so it can reach WIDTH without wrapping.
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH) + 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q,    acc_d;
    logic [PW-1:0]   mcand_q,  mcand_d;
    logic [PW-1:0]   result_q, result_d;
    logic [WIDTH:0]  mplr_q,   mplr_d;
    logic [SW-1:0]   step_q,   step_d;

    logic            w_accept;
    logic [1:0]      w_pair;
    logic [PW-1:0]   w_acc_next;

    // The multiplicand register is shifted left and the recoded multiplier
    // shifted right once per step, so the current Booth pair always sits in
    // the two low bits of mplr_q and mcand_q already equals mcand << step.
    assign w_pair   = mplr_q[1:0];
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign result    = result_q;

    // Booth digit evaluation: +mcand for 01, -mcand for 10, hold otherwise.
    // Arithmetic wraps modulo 2^PW.
    always_comb begin
        w_acc_next = acc_q;
        case (w_pair)
            2'b01:   w_acc_next = acc_q + mcand_q;
            2'b10:   w_acc_next = acc_q - mcand_q;
            default: w_acc_next = acc_q;
        endcase
    end

    // Next-state and datapath update logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        step_d   = step_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    mcand_d = {{WIDTH{op_1[WIDTH-1]}}, op_1};
                    mplr_d  = {op_2, 1'b0};
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                acc_d   = w_acc_next;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                step_d  = step_q + SW'(1);
                // The final digit is the sign digit; the product is complete
                // once it has been folded in, regardless of operand values.
                if (step_q == LAST_STEP) begin
                    result_d = w_acc_next;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, shifted operands, step count, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            step_q   <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            step_q   <= step_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mul.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_booth_seq_mul
//  Purpose  : Self-checking bench for booth_seq_mul (WIDTH=8 and WIDTH=16).
//             Expected products are queued at operand acceptance and
//             compared when the product handshake completes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_seq_mul;

    localparam int N8  = 1500;
    localparam int N16 = 600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  op_1, op_2;
    logic [15:0] result;

    // WIDTH=16 instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] op_1_16, op_2_16;
    logic [31:0] result16;

    booth_seq_mul #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_1      (op_1),
        .op_2      (op_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    booth_seq_mul #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .op_1      (op_1_16),
        .op_2      (op_2_16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .result    (result16),
        .busy      (busy16)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] sb8[$];
    logic [31:0] sb16[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitors, sampled on the falling edge
    // ------------------------------------------------------------------
    logic signed [15:0] p8;
    logic        [15:0] e8;
    logic        [15:0] last_res8;
    logic               pov8 = 1'b0;
    int                 acc_edge8 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                p8 = $signed(op_1) * $signed(op_2);
                sb8.push_back(p8);
                acc_edge8 = cyc + 1;
            end
            if (out_valid && !pov8)
                check_eq("w8_latency", cyc - acc_edge8, 8);
            if (out_valid && pov8)
                check_eq("w8_hold", result, last_res8);
            if (out_valid && out_ready) begin
                if (sb8.size() == 0) begin
                    check_eq("w8_unexpected_output", 1, 0);
                end else begin
                    e8 = sb8.pop_front();
                    check_eq("w8_result", result, e8);
                end
            end
            pov8      = out_valid;
            last_res8 = result;
        end
    end

    logic signed [31:0] p16;
    logic        [31:0] e16;
    logic        [31:0] last_res16;
    logic               pov16 = 1'b0;
    int                 acc_edge16 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid16 && in_ready16) begin
                p16 = $signed(op_1_16) * $signed(op_2_16);
                sb16.push_back(p16);
                acc_edge16 = cyc + 1;
            end
            if (out_valid16 && !pov16)
                check_eq("w16_latency", cyc - acc_edge16, 16);
            if (out_valid16 && pov16)
                check_eq("w16_hold", result16, last_res16);
            if (out_valid16 && out_ready16) begin
                if (sb16.size() == 0) begin
                    check_eq("w16_unexpected_output", 1, 0);
                end else begin
                    e16 = sb16.pop_front();
                    check_eq("w16_result", result16, e16);
                end
            end
            pov16      = out_valid16;
            last_res16 = result16;
        end
    end

    // ------------------------------------------------------------------
    // One directed WIDTH=8 transaction with a known product
    // ------------------------------------------------------------------
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_c);
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1;
        op_1     = a;
        op_2     = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("wait_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_1     = 8'($urandom);
        op_2     = 8'($urandom);
        check_eq("in_ready_after_accept", in_ready, 0);
        check_eq("busy_in_run", busy, 1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("wait_out_valid", out_valid, 1);
        check_eq("directed_result", result, exp_c);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("back_to_idle", in_ready, 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int t;
        int sent8, sent16, guard8, guard16;
        logic fired8, fired16;

        rst         = 1'b1;
        in_valid    = 1'b0;  op_1    = '0; op_2    = '0; out_ready   = 1'b0;
        in_valid16  = 1'b0;  op_1_16 = '0; op_2_16 = '0; out_ready16 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",   in_ready,    0);
        check_eq("rst_out_valid",  out_valid,   0);
        check_eq("rst_result",     result,      0);
        check_eq("rst_busy",       busy,        0);
        check_eq("rst_in_ready16", in_ready16,  0);
        check_eq("rst_result16",   result16,    0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_in_ready", in_ready, 1);
        check_eq("idle_busy",     busy,     0);

        // Basic and corner-case products
        do_op8(8'd3,   8'd5,   16'h000F);
        do_op8(8'h80,  8'h80,  16'h4000);
        do_op8(8'd127, 8'h80,  16'hC080);
        do_op8(8'h55,  8'h00,  16'h0000);
        do_op8(8'h00,  8'hAA,  16'h0000);

        // Consumer stall with extra producer requests during RUN and DONE
        @(posedge clk); #1;
        in_valid = 1'b1; op_1 = 8'h12; op_2 = 8'h34;
        check_eq("stall_accept_ready", in_ready, 1);
        @(posedge clk); #1;
        op_1 = 8'h7F; op_2 = 8'h7F;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            t++;
        end
        check_eq("stall_wait_out_valid", out_valid, 1);
        repeat (20) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            op_1 = 8'($urandom);
            op_2 = 8'($urandom);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_result",    result,    16'h03A8);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("stall_release_ov",    out_valid, 0);
        check_eq("stall_release_ready", in_ready,  1);
        do_op8(8'hF9, 8'd6, 16'hFFD6);

        // Asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        in_valid = 1'b1; op_1 = 8'h5A; op_2 = 8'hC3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_result",    result,    0);
        check_eq("abort_busy",      busy,      0);
        check_eq("abort_in_ready",  in_ready,  0);
        rst = 1'b0;
        sb8.delete();
        @(posedge clk); #1;
        check_eq("post_abort_ready", in_ready,  1);
        check_eq("post_abort_ov",    out_valid, 0);
        do_op8(8'hFF, 8'hFF, 16'h0001);

        // Random traffic on both widths with producer and consumer stalls
        fork
            begin
                sent8 = 0; guard8 = 0;
                while (sent8 < N8 && guard8 < 60000) begin
                    fired8 = in_valid && in_ready;
                    @(posedge clk); #1;
                    guard8++;
                    if (fired8) begin
                        sent8++;
                        in_valid = 1'b0;
                    end
                    if (!in_valid && sent8 < N8 && ($urandom % 4) != 0) begin
                        in_valid = 1'b1;
                        op_1 = 8'($urandom);
                        op_2 = 8'($urandom);
                    end
                    out_ready = ($urandom % 3) != 0;
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
                t = 0;
                while ((sb8.size() != 0 || out_valid) && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                check_eq("w8_sent", sent8, N8);
                check_eq("w8_drained", sb8.size(), 0);
                out_ready = 1'b0;
            end
            begin
                int t2;
                sent16 = 0; guard16 = 0;
                while (sent16 < N16 && guard16 < 60000) begin
                    fired16 = in_valid16 && in_ready16;
                    @(posedge clk); #1;
                    guard16++;
                    if (fired16) begin
                        sent16++;
                        in_valid16 = 1'b0;
                    end
                    if (!in_valid16 && sent16 < N16 && ($urandom % 4) != 0) begin
                        in_valid16 = 1'b1;
                        op_1_16 = 16'($urandom);
                        op_2_16 = 16'($urandom);
                    end
                    out_ready16 = ($urandom % 3) != 0;
                end
                in_valid16  = 1'b0;
                out_ready16 = 1'b1;
                t2 = 0;
                while ((sb16.size() != 0 || out_valid16) && t2 < 100) begin
                    @(posedge clk); #1;
                    t2++;
                end
                check_eq("w16_sent", sent16, N16);
                check_eq("w16_drained", sb16.size(), 0);
                out_ready16 = 1'b0;
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
